// File: rtl/cu_issue_sched.sv
// ---------------------------------------------------------------------------
// cu_issue_sched
//   Issue scheduler and RF write-port arbiter for the compute unit.
//   - Accepts one op per cycle from the program sequencer and pulses the
//     enable of the selected unit (ALU, multiplier or shifter) in the same
//     cycle.
//   - Keeps a reservation table of the single crossbar->RF write slot. An op
//     that writes the RF books the slot L cycles ahead, where L is its unit's
//     result latency. Slot 0 is the write happening in the current cycle.
//   - Stalls on structural (write-slot collision), RAW and WAW hazards.
//   - Slots bus-connect RF writes in between CU writes. A small FSM drains
//     the table and then performs the bus write in a slot of its own.
//
// Configuration macro:
//   CU_STALL_CNT_EN  adds a saturating 16-bit counter of stalled request
//                    cycles (cu_stall_cnt) with a synchronous clear
//                    (ps_cu_cnt_clr). When undefined, neither port exists.
//
// Ports:
//   clk            clock
//   reset          asynchronous, active-low reset
//   ps_cu_req      op valid from the sequencer
//   ps_cu_unit     00 ALU, 01 MUL, 10 SHF, 11 reserved (accepted, no effect)
//   ps_cu_wr       op writes the RF
//   ps_cu_wadd     destination RF address
//   ps_cu_raddx    source X address
//   ps_cu_raddy    source Y address
//   cu_ps_rdy      op accepted this cycle when ps_cu_req & cu_ps_rdy
//   bc_req         bus-connect RF write request, held until granted
//   bc_add         bus-connect write address
//   bc_gnt         bus write performed this cycle
//   cu_alu_en      ALU enable pulse
//   cu_mul_en      multiplier enable pulse
//   cu_shf_en      shifter enable pulse
//   cu_xb_raddx    read address X to crossbar/RF (0 when no request)
//   cu_xb_raddy    read address Y to crossbar/RF (0 when no request)
//   cu_xb_w_cuEn   one-hot write source this cycle (bit0 ALU, bit1 MUL, bit2 SHF)
//   cu_xb_w_bcEn   bus-connect write this cycle
//   cu_xb_wadd     RF write address this cycle
//   cu_stall_cnt   (CU_STALL_CNT_EN) stalled request cycles, saturating
//   ps_cu_cnt_clr  (CU_STALL_CNT_EN) synchronous clear of cu_stall_cnt
// ---------------------------------------------------------------------------
module cu_issue_sched #(
    parameter int ADDRESS_WIDTH = 4,
    parameter int SIGNAL_WIDTH  = 3,
    parameter int ALU_LAT       = 1,
    parameter int SHF_LAT       = 1,
    parameter int MUL_LAT       = 2
) (
`ifdef CU_STALL_CNT_EN
    input  logic                     ps_cu_cnt_clr,
    output logic [15:0]              cu_stall_cnt,
`endif
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     ps_cu_req,
    input  logic [1:0]               ps_cu_unit,
    input  logic                     ps_cu_wr,
    input  logic [ADDRESS_WIDTH-1:0] ps_cu_wadd,
    input  logic [ADDRESS_WIDTH-1:0] ps_cu_raddx,
    input  logic [ADDRESS_WIDTH-1:0] ps_cu_raddy,
    output logic                     cu_ps_rdy,
    input  logic                     bc_req,
    input  logic [ADDRESS_WIDTH-1:0] bc_add,
    output logic                     bc_gnt,
    output logic                     cu_alu_en,
    output logic                     cu_mul_en,
    output logic                     cu_shf_en,
    output logic [ADDRESS_WIDTH-1:0] cu_xb_raddx,
    output logic [ADDRESS_WIDTH-1:0] cu_xb_raddy,
    output logic [SIGNAL_WIDTH-1:0]  cu_xb_w_cuEn,
    output logic                     cu_xb_w_bcEn,
    output logic [ADDRESS_WIDTH-1:0] cu_xb_wadd
);

    localparam int AW = ADDRESS_WIDTH;
    localparam int SW = SIGNAL_WIDTH;

    // Reservation depth: the longest unit latency.
    localparam int MAX_AS = (ALU_LAT > SHF_LAT) ? ALU_LAT : SHF_LAT;
    localparam int D      = (MAX_AS > MUL_LAT) ? MAX_AS : MUL_LAT;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DRAIN,
        ST_BCWR
    } state_t;

    typedef struct packed {
        logic          vld;
        logic [SW-1:0] src;
        logic [AW-1:0] wadd;
    } slot_t;

    state_t state_q;
    slot_t  rsv_q [D];
    slot_t  rsv_d [D];

    // Op decode
    logic          is_alu, is_mul, is_shf, is_unit;
    int            lat;
    logic [SW-1:0] src;
    logic          struct_hz, raw_hz, waw_hz;
    logic          rdy_int, issue, tail_empty;

    // NOTE: every variable written in an always_comb gets a default first, so
    // no path leaves it unassigned and no latch is inferred.
    always_comb begin
        is_alu  = (ps_cu_unit == 2'b00);
        is_mul  = (ps_cu_unit == 2'b01);
        is_shf  = (ps_cu_unit == 2'b10);
        is_unit = is_alu | is_mul | is_shf;
        lat     = 0;
        src     = '0;
        case (ps_cu_unit)
            2'b00: begin lat = ALU_LAT; src = SW'(1); end
            2'b01: begin lat = MUL_LAT; src = SW'(2); end
            2'b10: begin lat = SHF_LAT; src = SW'(4); end
            default: begin lat = 0; src = '0; end
        endcase
    end

    // Hazard detection. Only RF-writing ops occupy the table, so every valid
    // slot is a pending write to compare against.
    always_comb begin
        struct_hz  = 1'b0;
        raw_hz     = 1'b0;
        waw_hz     = 1'b0;
        tail_empty = 1'b1;
        for (int i = 0; i < D; i++) begin
            // Slot lat shifts into slot lat-1, which the new op would book.
            // A unit with latency D always finds a free slot D-1.
            if (is_unit && (i == lat) && rsv_q[i].vld)
                struct_hz = 1'b1;
            if (rsv_q[i].vld && ((rsv_q[i].wadd == ps_cu_raddx) ||
                                 (rsv_q[i].wadd == ps_cu_raddy)))
                raw_hz = 1'b1;
            if (rsv_q[i].vld && ps_cu_wr && (rsv_q[i].wadd == ps_cu_wadd))
                waw_hz = 1'b1;
            // Slots 1..D-1 empty means the table is empty after this edge.
            if ((i > 0) && rsv_q[i].vld)
                tail_empty = 1'b0;
        end
    end

    // A bus request seen in RUN takes priority over the op in the same cycle.
    assign rdy_int = (state_q == ST_RUN) && !bc_req &&
                     !struct_hz && !raw_hz && !waw_hz;
    assign issue   = ps_cu_req && rdy_int;

    // Next table: shift toward slot 0 and drop in the new reservation.
    always_comb begin
        rsv_d = '{default: '0};
        for (int i = 0; i < D - 1; i++)
            rsv_d[i] = rsv_q[i + 1];
        for (int i = 0; i < D; i++) begin
            if (issue && ps_cu_wr && is_unit && (i == lat - 1)) begin
                rsv_d[i].vld  = 1'b1;
                rsv_d[i].src  = src;
                rsv_d[i].wadd = ps_cu_wadd;
            end
        end
    end

    // NOTE: the table is reset because its valid bits gate real RF writes;
    // in-flight writes must be dropped immediately on reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < D; i++)
                rsv_q[i] <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples values from before the edge.
            for (int i = 0; i < D; i++)
                rsv_q[i] <= rsv_d[i];
        end
    end

    // Bus-connect FSM: drain all pending CU writes, then take one slot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
        end else begin
            case (state_q)
                ST_RUN:   if (bc_req) state_q <= ST_DRAIN;
                ST_DRAIN: if (tail_empty) state_q <= ST_BCWR;
                ST_BCWR:  state_q <= ST_RUN;
                default:  state_q <= ST_RUN;
            endcase
        end
    end

    // Sequencer-facing outputs are combinational from the request, so they
    // are explicitly forced low while reset is asserted.
    assign cu_ps_rdy   = reset && rdy_int;
    assign cu_alu_en   = reset && issue && is_alu;
    assign cu_mul_en   = reset && issue && is_mul;
    assign cu_shf_en   = reset && issue && is_shf;
    assign cu_xb_raddx = (reset && ps_cu_req) ? ps_cu_raddx : '0;
    assign cu_xb_raddy = (reset && ps_cu_req) ? ps_cu_raddy : '0;

    // Write port. BCWR is only reached with an empty table, so a bus write
    // never coincides with a CU write.
    assign bc_gnt       = (state_q == ST_BCWR);
    assign cu_xb_w_bcEn = (state_q == ST_BCWR);
    assign cu_xb_w_cuEn = rsv_q[0].vld ? rsv_q[0].src : '0;
    assign cu_xb_wadd   = (state_q == ST_BCWR) ? bc_add :
                          (rsv_q[0].vld ? rsv_q[0].wadd : '0);

`ifdef CU_STALL_CNT_EN
    logic [15:0] stall_cnt_q;

    // Counts cycles in which the sequencer waited; clear wins over count.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            stall_cnt_q <= '0;
        else if (ps_cu_cnt_clr)
            stall_cnt_q <= '0;
        else if (ps_cu_req && !rdy_int && (stall_cnt_q != 16'hFFFF))
            stall_cnt_q <= stall_cnt_q + 16'd1;
    end

    assign cu_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cu_issue_sched.sv
// ---------------------------------------------------------------------------
// tb_cu_issue_sched
//   Directed bench for cu_issue_sched with default parameters
//   (ALU_LAT=1, SHF_LAT=1, MUL_LAT=2, D=2). Each cycle: inputs are driven
//   just after the rising edge and outputs are checked on the falling edge.
//   Define CU_STALL_CNT_EN for both files to exercise the stall counter.
// ---------------------------------------------------------------------------
module tb_cu_issue_sched;

    localparam int AW = 4;
    localparam int SW = 3;

    localparam logic [1:0] U_ALU = 2'b00;
    localparam logic [1:0] U_MUL = 2'b01;
    localparam logic [1:0] U_SHF = 2'b10;
    localparam logic [1:0] U_RSV = 2'b11;

    logic          clk = 1'b0;
    logic          reset;
    logic          ps_cu_req;
    logic [1:0]    ps_cu_unit;
    logic          ps_cu_wr;
    logic [AW-1:0] ps_cu_wadd, ps_cu_raddx, ps_cu_raddy;
    logic          cu_ps_rdy;
    logic          bc_req;
    logic [AW-1:0] bc_add;
    logic          bc_gnt;
    logic          cu_alu_en, cu_mul_en, cu_shf_en;
    logic [AW-1:0] cu_xb_raddx, cu_xb_raddy;
    logic [SW-1:0] cu_xb_w_cuEn;
    logic          cu_xb_w_bcEn;
    logic [AW-1:0] cu_xb_wadd;
`ifdef CU_STALL_CNT_EN
    logic          ps_cu_cnt_clr = 1'b0;
    logic [15:0]   cu_stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    cu_issue_sched dut (
`ifdef CU_STALL_CNT_EN
        .ps_cu_cnt_clr (ps_cu_cnt_clr),
        .cu_stall_cnt  (cu_stall_cnt),
`endif
        .clk           (clk),
        .reset         (reset),
        .ps_cu_req     (ps_cu_req),
        .ps_cu_unit    (ps_cu_unit),
        .ps_cu_wr      (ps_cu_wr),
        .ps_cu_wadd    (ps_cu_wadd),
        .ps_cu_raddx   (ps_cu_raddx),
        .ps_cu_raddy   (ps_cu_raddy),
        .cu_ps_rdy     (cu_ps_rdy),
        .bc_req        (bc_req),
        .bc_add        (bc_add),
        .bc_gnt        (bc_gnt),
        .cu_alu_en     (cu_alu_en),
        .cu_mul_en     (cu_mul_en),
        .cu_shf_en     (cu_shf_en),
        .cu_xb_raddx   (cu_xb_raddx),
        .cu_xb_raddy   (cu_xb_raddy),
        .cu_xb_w_cuEn  (cu_xb_w_cuEn),
        .cu_xb_w_bcEn  (cu_xb_w_bcEn),
        .cu_xb_wadd    (cu_xb_wadd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic idle();
        ps_cu_req   = 1'b0;
        ps_cu_unit  = U_ALU;
        ps_cu_wr    = 1'b0;
        ps_cu_wadd  = '0;
        ps_cu_raddx = '0;
        ps_cu_raddy = '0;
        bc_req      = 1'b0;
        bc_add      = '0;
    endtask

    task automatic op(input logic [1:0] unit, input logic wr,
                      input logic [AW-1:0] wadd, input logic [AW-1:0] rx,
                      input logic [AW-1:0] ry);
        ps_cu_req   = 1'b1;
        ps_cu_unit  = unit;
        ps_cu_wr    = wr;
        ps_cu_wadd  = wadd;
        ps_cu_raddx = rx;
        ps_cu_raddy = ry;
    endtask

    initial begin
        // ---- reset: outputs low even with a request present ----
        reset = 1'b0;
        idle();
        op(U_ALU, 1'b1, 4'd3, 4'd5, 4'd6);
        #3;
        check("rst_rdy", cu_ps_rdy, 0);
        check("rst_alu_en", cu_alu_en, 0);
        check("rst_raddx", cu_xb_raddx, 0);
        check("rst_w_cuEn", cu_xb_w_cuEn, 0);
        check("rst_bc_gnt", bc_gnt, 0);
`ifdef CU_STALL_CNT_EN
        check("rst_cnt", cu_stall_cnt, 0);
`endif
        idle();
        #9 reset = 1'b1;

        // ---- 1: single ALU op, write one cycle later ----
        next_cyc(); op(U_ALU, 1'b1, 4'd3, 4'd1, 4'd2); sample();
        check("t1_rdy", cu_ps_rdy, 1);
        check("t1_alu_en", cu_alu_en, 1);
        check("t1_mul_en", cu_mul_en, 0);
        check("t1_raddx", cu_xb_raddx, 1);
        check("t1_raddy", cu_xb_raddy, 2);
        check("t1_c0_w_cuEn", cu_xb_w_cuEn, 0);
        next_cyc(); idle(); sample();
        check("t1_c1_alu_en", cu_alu_en, 0);
        check("t1_c1_raddx", cu_xb_raddx, 0);
        check("t1_c1_w_cuEn", cu_xb_w_cuEn, 3'b001);
        check("t1_c1_wadd", cu_xb_wadd, 3);
        next_cyc(); sample();
        check("t1_c2_w_cuEn", cu_xb_w_cuEn, 0);
        check("t1_c2_wadd", cu_xb_wadd, 0);

        // ---- 2: MUL then ALU, structural stall for one cycle ----
        next_cyc(); op(U_MUL, 1'b1, 4'd5, 4'd8, 4'd8); sample();
        check("t2_c0_rdy", cu_ps_rdy, 1);
        check("t2_c0_mul_en", cu_mul_en, 1);
        next_cyc(); op(U_ALU, 1'b1, 4'd6, 4'd8, 4'd8); sample();
        check("t2_c1_rdy", cu_ps_rdy, 0);
        check("t2_c1_alu_en", cu_alu_en, 0);
        check("t2_c1_w_cuEn", cu_xb_w_cuEn, 0);
        next_cyc(); sample();
        check("t2_c2_rdy", cu_ps_rdy, 1);
        check("t2_c2_alu_en", cu_alu_en, 1);
        check("t2_c2_w_cuEn", cu_xb_w_cuEn, 3'b010);
        check("t2_c2_wadd", cu_xb_wadd, 5);
        next_cyc(); idle(); sample();
        check("t2_c3_w_cuEn", cu_xb_w_cuEn, 3'b001);
        check("t2_c3_wadd", cu_xb_wadd, 6);
        next_cyc(); sample();
        check("t2_c4_w_cuEn", cu_xb_w_cuEn, 0);

        // ---- 3a: RAW stall on source X ----
        next_cyc(); op(U_ALU, 1'b1, 4'd4, 4'd8, 4'd8); sample();
        check("t3a_c0_rdy", cu_ps_rdy, 1);
        next_cyc(); op(U_ALU, 1'b0, 4'd0, 4'd4, 4'd8); sample();
        check("t3a_c1_rdy", cu_ps_rdy, 0);
        check("t3a_c1_w_cuEn", cu_xb_w_cuEn, 3'b001);
        check("t3a_c1_wadd", cu_xb_wadd, 4);
        next_cyc(); sample();
        check("t3a_c2_rdy", cu_ps_rdy, 1);
        check("t3a_c2_alu_en", cu_alu_en, 1);
        next_cyc(); idle(); sample();
        check("t3a_c3_w_cuEn_nowr", cu_xb_w_cuEn, 0);

        // ---- 3b: WAW stall, MUL wadd=7 then SHF wadd=7 ----
        next_cyc(); op(U_MUL, 1'b1, 4'd7, 4'd8, 4'd8); sample();
        check("t3b_c0_rdy", cu_ps_rdy, 1);
        next_cyc(); op(U_SHF, 1'b1, 4'd7, 4'd8, 4'd8); sample();
        check("t3b_c1_rdy", cu_ps_rdy, 0);
        check("t3b_c1_shf_en", cu_shf_en, 0);
        next_cyc(); sample();
        check("t3b_c2_w_cuEn", cu_xb_w_cuEn, 3'b010);
        check("t3b_c2_wadd", cu_xb_wadd, 7);
        next_cyc(); sample();
        check("t3b_c3_rdy", cu_ps_rdy, 1);
        check("t3b_c3_shf_en", cu_shf_en, 1);
        next_cyc(); idle(); sample();
        check("t3b_c4_w_cuEn", cu_xb_w_cuEn, 3'b100);
        check("t3b_c4_wadd", cu_xb_wadd, 7);

        // ---- 4: bus-connect write after draining a MUL write ----
        next_cyc(); op(U_MUL, 1'b1, 4'd2, 4'd8, 4'd8); sample();
        check("t4_c0_rdy", cu_ps_rdy, 1);
        next_cyc(); op(U_ALU, 1'b1, 4'd10, 4'd8, 4'd8);
        bc_req = 1'b1; bc_add = 4'd9; sample();
        check("t4_c1_rdy", cu_ps_rdy, 0);
        check("t4_c1_bc_gnt", bc_gnt, 0);
        next_cyc(); sample();
        check("t4_c2_rdy", cu_ps_rdy, 0);
        check("t4_c2_bc_gnt", bc_gnt, 0);
        check("t4_c2_w_cuEn", cu_xb_w_cuEn, 3'b010);
        check("t4_c2_wadd", cu_xb_wadd, 2);
        next_cyc(); sample();
        check("t4_c3_bc_gnt", bc_gnt, 1);
        check("t4_c3_w_bcEn", cu_xb_w_bcEn, 1);
        check("t4_c3_wadd", cu_xb_wadd, 9);
        check("t4_c3_w_cuEn", cu_xb_w_cuEn, 0);
        check("t4_c3_rdy", cu_ps_rdy, 0);
        next_cyc(); bc_req = 1'b0; bc_add = '0; sample();
        check("t4_c4_rdy", cu_ps_rdy, 1);
        check("t4_c4_alu_en", cu_alu_en, 1);
        check("t4_c4_bc_gnt", bc_gnt, 0);
        next_cyc(); idle(); sample();
        check("t4_c5_w_cuEn", cu_xb_w_cuEn, 3'b001);
        check("t4_c5_wadd", cu_xb_wadd, 10);

        // ---- reserved unit: accepted, no enable, no write ----
        next_cyc(); op(U_RSV, 1'b1, 4'd12, 4'd8, 4'd8); sample();
        check("u3_rdy", cu_ps_rdy, 1);
        check("u3_en", {cu_alu_en, cu_mul_en, cu_shf_en}, 0);
        next_cyc(); idle(); sample();
        check("u3_w_cuEn", cu_xb_w_cuEn, 0);
        check("u3_wadd", cu_xb_wadd, 0);

        // ---- 5: reset mid-cycle drops the in-flight MUL write ----
        next_cyc(); op(U_MUL, 1'b1, 4'd5, 4'd8, 4'd8); sample();
        check("t5_c0_rdy", cu_ps_rdy, 1);
        next_cyc(); op(U_ALU, 1'b1, 4'd11, 4'd3, 4'd3);
        #2 reset = 1'b0;
        #1;
        check("t5_rst_rdy", cu_ps_rdy, 0);
        check("t5_rst_alu_en", cu_alu_en, 0);
        check("t5_rst_raddx", cu_xb_raddx, 0);
        check("t5_rst_raddy", cu_xb_raddy, 0);
        check("t5_rst_w_cuEn", cu_xb_w_cuEn, 0);
        idle();
        #2 reset = 1'b1;
        next_cyc(); sample();
        check("t5_c2_w_cuEn", cu_xb_w_cuEn, 0);
        check("t5_c2_wadd", cu_xb_wadd, 0);

`ifdef CU_STALL_CNT_EN
        // ---- 6: stall counter ----
        next_cyc(); ps_cu_cnt_clr = 1'b1; sample();
        next_cyc(); ps_cu_cnt_clr = 1'b0; sample();
        check("t6_clr0", cu_stall_cnt, 0);
        next_cyc(); op(U_ALU, 1'b0, 4'd0, 4'd8, 4'd8);
        bc_req = 1'b1; bc_add = 4'd1; sample();
        check("t6_c0_rdy", cu_ps_rdy, 0);
        next_cyc(); sample();
        next_cyc(); sample();
        check("t6_c2_bc_gnt", bc_gnt, 1);
        next_cyc(); bc_req = 1'b0; bc_add = '0; sample();
        check("t6_c3_rdy", cu_ps_rdy, 1);
        check("t6_cnt3", cu_stall_cnt, 3);
        next_cyc(); idle(); ps_cu_cnt_clr = 1'b1; sample();
        next_cyc(); ps_cu_cnt_clr = 1'b0; sample();
        check("t6_clr1", cu_stall_cnt, 0);
        force dut.stall_cnt_q = 16'hFFFF;
        #1 release dut.stall_cnt_q;
        next_cyc(); op(U_ALU, 1'b1, 4'd4, 4'd8, 4'd8); sample();
        next_cyc(); op(U_ALU, 1'b0, 4'd0, 4'd4, 4'd4); sample();
        check("t6_sat_stall", cu_ps_rdy, 0);
        next_cyc(); idle(); sample();
        check("t6_sat", cu_stall_cnt, 16'hFFFF);
`endif

        next_cyc();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
